timer_counter: RTL

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/timer_counter.sv
// Programmable timer/counter with prescaler, four count modes (up-wrap,
// down-wrap, up-saturate, one-shot), a one-cycle terminal-count pulse and a
// sticky terminal-count flag.
module timer_counter #(
    parameter int WIDTH     = 8,
    parameter int PSC_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 write,
    input  logic [WIDTH-1:0]     in,
    input  logic                 limit_write,
    input  logic [WIDTH-1:0]     limit_in,
    input  logic [1:0]           mode,
    input  logic [PSC_WIDTH-1:0] prescale,
    input  logic                 start,
    input  logic                 flag_clear,
    output logic [WIDTH-1:0]     out,
    output logic                 tc,
    output logic                 flag,
    output logic                 running
);

    localparam logic [1:0] MODE_UP_WRAP   = 2'b00;
    localparam logic [1:0] MODE_DOWN_WRAP = 2'b01;
    localparam logic [1:0] MODE_UP_SAT    = 2'b10;
    localparam logic [1:0] MODE_ONE_SHOT  = 2'b11;

    localparam logic [WIDTH-1:0]     CNT_ONE = WIDTH'(1);
    localparam logic [PSC_WIDTH-1:0] PSC_ONE = PSC_WIDTH'(1);

    logic [WIDTH-1:0]     limit;
    logic [PSC_WIDTH-1:0] psc;

    logic                 step;
    logic                 arm;
    logic [WIDTH-1:0]     cnt_next;
    logic [PSC_WIDTH-1:0] psc_next;
    logic                 tc_next;
    logic                 run_next;

    // A step fires on the enabled cycle where the prescaler reaches its terminal value.
    assign step = enable && (psc == prescale);
    // Start only has meaning in one-shot mode.
    assign arm  = start && (mode == MODE_ONE_SHOT);

    // Next-state logic: load/arm take precedence over a count step; a load
    // or arm also restarts the prescaler so the first step is a full period away.
    always_comb begin
        cnt_next = out;
        tc_next  = 1'b0;
        run_next = (mode == MODE_ONE_SHOT) ? running : 1'b0;

        if (write || arm) begin
            psc_next = '0;
        end else if (enable) begin
            psc_next = (psc == prescale) ? '0 : psc + PSC_ONE;
        end else begin
            psc_next = psc;
        end

        if (write) begin
            cnt_next = in;
        end else if (arm) begin
            cnt_next = '0;
            run_next = 1'b1;
        end else if (step) begin
            case (mode)
                MODE_UP_WRAP: begin
                    if (out == limit) begin
                        cnt_next = '0;
                        tc_next  = 1'b1;
                    end else begin
                        cnt_next = out + CNT_ONE;
                    end
                end
                MODE_DOWN_WRAP: begin
                    if (out == '0) begin
                        cnt_next = limit;
                        tc_next  = 1'b1;
                    end else begin
                        cnt_next = out - CNT_ONE;
                    end
                end
                MODE_UP_SAT: begin
                    // out < limit here, so out+1 cannot overflow.
                    if (out < limit) begin
                        cnt_next = out + CNT_ONE;
                        tc_next  = ((out + CNT_ONE) == limit);
                    end
                end
                default: begin
                    if (running) begin
                        if (out == limit) begin
                            run_next = 1'b0;
                            tc_next  = 1'b1;
                        end else begin
                            cnt_next = out + CNT_ONE;
                        end
                    end
                end
            endcase
        end
    end

    // State register; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            out     <= '0;
            limit   <= '1;
            psc     <= '0;
            tc      <= 1'b0;
            flag    <= 1'b0;
            running <= 1'b0;
        end else begin
            out     <= cnt_next;
            psc     <= psc_next;
            tc      <= tc_next;
            running <= run_next;
            // A new terminal count wins over a coincident clear.
            flag    <= tc_next | (flag & ~flag_clear);
            if (limit_write) begin
                limit <= limit_in;
            end
        end
    end

endmodule
